// File: rtl/gpu_pkg.sv
// Shared GPU types and screen geometry used by the
// rasterizer, framebuffer and scanout stages.
package gpu_pkg;

    localparam int XW    = 10;
    localparam int YW    = 9;
    localparam int H_RES = 640;
    localparam int V_RES = 480;

    typedef enum logic {
        IDLE = 1'b0,
        DRAW = 1'b1
    } state_t;

    typedef logic [7:0] color_t;

endpackage

// File: rtl/line_raster.sv
// Bresenham line rasterizer driving the framebuffer
// write port one pixel per cycle, clipped to the screen.
module line_raster
    import gpu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [XW-1:0] x0,
    input  logic [YW-1:0] y0,
    input  logic [XW-1:0] x1,
    input  logic [YW-1:0] y1,
    input  color_t        color,
    input  logic          hold,
    output logic          busy,
    output logic          done,
    output logic          fb_we,
    output logic [XW-1:0] fb_px,
    output logic [YW-1:0] fb_py,
    output color_t        fb_color
);

    localparam logic [XW-1:0] H_LIM = XW'(H_RES);
    localparam logic [YW-1:0] V_LIM = YW'(V_RES);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [XW-1:0]         r_px;
    logic [YW-1:0]         r_py;
    logic [XW-1:0]         r_x1;
    logic [YW-1:0]         r_y1;
    logic [XW-1:0]         r_dx;
    logic [YW-1:0]         r_dym;
    logic                  r_sx;
    logic                  r_sy;
    logic signed [XW+2:0]  r_err;
    color_t                r_color;

    logic                  w_step;
    logic                  w_at_end;
    logic signed [XW+3:0]  w_e2w;
    logic signed [XW+3:0]  w_e2;
    logic signed [XW+3:0]  w_dx_w;
    logic signed [XW+3:0]  w_dy_w;
    logic signed [XW+2:0]  w_dx_n;
    logic signed [XW+2:0]  w_dy_n;
    logic signed [XW+2:0]  w_err_nxt;
    logic [XW-1:0]         w_px_nxt;
    logic [YW-1:0]         w_py_nxt;
    logic [XW-1:0]         w_adx;
    logic [YW-1:0]         w_ady;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_at_end    = (r_px == r_x1) && (r_py == r_y1);
        w_step      = (r_state == DRAW) && !hold;
        unique case (r_state)
            IDLE: if (start) w_state_nxt = DRAW;
            DRAW: if (w_step && w_at_end) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        busy  = (r_state == DRAW);
        done  = w_step && w_at_end;
        fb_we = w_step && (r_px < H_LIM) && (r_py < V_LIM);
    end

    // e2 is compared in one extra bit so the doubling never overflows
    always_comb begin
        w_e2w     = {r_err[XW+2], r_err};
        w_e2      = w_e2w <<< 1;
        w_dx_w    = $signed({4'b0, r_dx});
        w_dy_w    = -$signed({5'b0, r_dym});
        w_dx_n    = $signed({3'b0, r_dx});
        w_dy_n    = -$signed({4'b0, r_dym});
        w_err_nxt = r_err;
        w_px_nxt  = r_px;
        w_py_nxt  = r_py;
        if (w_e2 >= w_dy_w) begin
            w_err_nxt = w_err_nxt + w_dy_n;
            w_px_nxt  = r_sx ? r_px + XW'(1) : r_px - XW'(1);
        end
        if (w_e2 <= w_dx_w) begin
            w_err_nxt = w_err_nxt + w_dx_n;
            w_py_nxt  = r_sy ? r_py + YW'(1) : r_py - YW'(1);
        end
        w_adx = (x1 > x0) ? x1 - x0 : x0 - x1;
        w_ady = (y1 > y0) ? y1 - y0 : y0 - y1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_px    <= '0;
            r_py    <= '0;
            r_x1    <= '0;
            r_y1    <= '0;
            r_dx    <= '0;
            r_dym   <= '0;
            r_sx    <= 1'b0;
            r_sy    <= 1'b0;
            r_err   <= '0;
            r_color <= '0;
        end else if (r_state == IDLE) begin
            if (start) begin
                r_px    <= x0;
                r_py    <= y0;
                r_x1    <= x1;
                r_y1    <= y1;
                r_dx    <= w_adx;
                r_dym   <= w_ady;
                r_sx    <= (x0 < x1);
                r_sy    <= (y0 < y1);
                r_err   <= $signed({3'b0, w_adx}) - $signed({4'b0, w_ady});
                r_color <= color;
            end
        end else if (w_step && !w_at_end) begin
            r_px  <= w_px_nxt;
            r_py  <= w_py_nxt;
            r_err <= w_err_nxt;
        end
    end

    assign fb_px    = r_px;
    assign fb_py    = r_py;
    assign fb_color = r_color;

endmodule

// File: tb/tb_line_raster.sv
// Randomized bench for line_raster against a reference
// Bresenham model operating on plain integers.
module tb_line_raster;
    import gpu_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [XW-1:0] x0 = '0;
    logic [YW-1:0] y0 = '0;
    logic [XW-1:0] x1 = '0;
    logic [YW-1:0] y1 = '0;
    color_t        color = '0;
    logic          hold = 1'b0;
    logic          busy;
    logic          done;
    logic          fb_we;
    logic [XW-1:0] fb_px;
    logic [YW-1:0] fb_py;
    color_t        fb_color;

    int checks = 0;
    int failures = 0;
    int qx[$];
    int qy[$];
    int n_we;

    line_raster dut (
        .clk(clk), .rst(rst), .start(start),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1),
        .color(color), .hold(hold),
        .busy(busy), .done(done), .fb_we(fb_we),
        .fb_px(fb_px), .fb_py(fb_py), .fb_color(fb_color)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got,
                       input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model(input int ax0, ay0, ax1, ay1);
        int x, y, dx, dy, sx, sy, err, e2;
        qx.delete();
        qy.delete();
        x  = ax0;
        y  = ay0;
        dx = iabs(ax1 - ax0);
        dy = -iabs(ay1 - ay0);
        sx = (ax0 < ax1) ? 1 : -1;
        sy = (ay0 < ay1) ? 1 : -1;
        err = dx + dy;
        forever begin
            qx.push_back(x);
            qy.push_back(y);
            if (x == ax1 && y == ay1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endtask

    // expects qx/qy preloaded; hold_at freezes 3 cycles at that index
    task automatic run_line(input int ax0, ay0, ax1, ay1,
                            input int col, input int hold_at,
                            input bit rnd);
        int k, cyc, held, n;
        bit h, ew;
        n = qx.size();
        n_we = 0;
        @(negedge clk);
        x0 = XW'(ax0); y0 = YW'(ay0);
        x1 = XW'(ax1); y1 = YW'(ay1);
        color = color_t'(col);
        start = 1'b1;
        hold = 1'b0;
        @(negedge clk);
        start = 1'b0;
        k = 0; cyc = 0; held = 0;
        while (k < n && cyc < 4000) begin
            if (k == hold_at && held < 3) begin
                h = 1'b1; held++;
            end else if (rnd) h = ($urandom_range(0, 3) == 0);
            else h = 1'b0;
            hold = h;
            if (rnd) begin
                start = ($urandom_range(0, 2) == 0);
                x0 = XW'($urandom); y0 = YW'($urandom);
                x1 = XW'($urandom); y1 = YW'($urandom);
                color = color_t'($urandom);
            end
            #1;
            ew = !h && qx[k] < H_RES && qy[k] < V_RES;
            chk("busy", busy, 1);
            chk("px", fb_px, qx[k]);
            chk("py", fb_py, qy[k]);
            chk("we", fb_we, ew);
            chk("done", done, !h && k == n - 1);
            chk("color", fb_color, col);
            if (fb_we) n_we++;
            if (!h) k++;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        hold = 1'b0;
        chk("timeout", cyc < 4000, 1);
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_we", fb_we, 0);
        chk("idle_color", fb_color, col);
    endtask

    initial begin
        int ax0, ay0, ax1, ay1, w, k;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_we", fb_we, 0);
        chk("rst_px", fb_px, 0);
        chk("rst_color", fb_color, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        qx = '{0, 1, 2, 3}; qy = '{0, 0, 0, 0};
        run_line(0, 0, 3, 0, 8'hAA, -1, 0);
        chk("horiz_we", n_we, 4);

        qx = '{5, 5, 4, 4, 3, 3}; qy = '{5, 6, 7, 8, 9, 10};
        run_line(5, 5, 3, 10, 8'h31, -1, 0);

        qx = '{637, 638, 639, 640, 641}; qy = '{479, 479, 479, 479, 479};
        run_line(637, 479, 641, 479, 8'h5C, -1, 0);
        chk("clip_we", n_we, 3);

        qx = '{10}; qy = '{10};
        run_line(10, 10, 10, 10, 8'h77, -1, 0);
        chk("point_we", n_we, 1);

        model(20, 30, 39, 35);
        run_line(20, 30, 39, 35, 8'h12, -1, 1);

        model(0, 0, 7, 7);
        run_line(0, 0, 7, 7, 8'hE1, 2, 0);
        chk("hold_we", n_we, 8);

        @(negedge clk);
        x0 = 0; y0 = 0; x1 = 9; y1 = 0; color = 8'h44;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("pre_abort_px", fb_px, 3);
        rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_we", fb_we, 0);
        chk("abort_px", fb_px, 0);
        chk("abort_color", fb_color, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_abort_busy", busy, 0);

        model(100, 50, 4, 200);
        run_line(100, 50, 4, 200, 8'h9A, -1, 0);

        for (int i = 0; i < 30; i++) begin
            ax0 = $urandom_range(0, 1023);
            ay0 = $urandom_range(0, 511);
            w = (i % 3 == 0) ? 1023 : 40;
            ax1 = $urandom_range(ax0 > w ? ax0 - w : 0,
                                 ax0 + w > 1023 ? 1023 : ax0 + w);
            ay1 = $urandom_range(ay0 > w ? ay0 - w : 0,
                                 ay0 + w > 511 ? 511 : ay0 + w);
            model(ax0, ay0, ax1, ay1);
            k = iabs(ax1 - ax0) > iabs(ay1 - ay0) ?
                iabs(ax1 - ax0) : iabs(ay1 - ay0);
            chk("model_len", qx.size(), k + 1);
            run_line(ax0, ay0, ax1, ay1, $urandom_range(0, 255),
                     -1, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
